// File: rtl/bram_port_pkg.sv
// Shared types for the BRAM port initiator: default-width word/address/strobe types,
// request/response records and the init/run state encoding.
package bram_port_pkg;

  localparam int BP_DATA_WIDTH = 32;
  localparam int BP_ADDR_WIDTH = 10;

  typedef logic [BP_ADDR_WIDTH-1:0]   baddr_t;
  typedef logic [BP_DATA_WIDTH-1:0]   bword_t;
  typedef logic [BP_DATA_WIDTH/8-1:0] bstrobe_t;

  typedef struct packed {
    baddr_t   addr;
    bstrobe_t strobe;
    bword_t   data;
  } bram_req_t;

  typedef struct packed {
    bword_t data;
  } bram_resp_t;

  typedef enum logic {INIT, RUN} bram_init_state_t;

endpackage

// File: rtl/bram_resp_fifo.sv
// Register FIFO holding BRAM read results until the client pops them; pointers wrap
// modulo DEPTH, head is a plain register read so it stays stable while not popped.
module bram_resp_fifo
  import bram_port_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count_q != '0);
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The initiator's credit check makes overflow impossible; catch it if that ever breaks.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/bram_port_initiator.sv
// Valid/ready initiator for one BRAM port; requests pass straight to the BRAM, responses
// return in order two edges later via a small buffer. BRAM_INIT_CLEAR_EN adds a zero-fill pass after reset.
module bram_port_initiator
  import bram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_strobe,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_write_en,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_data_in,
  input  logic [DATA_WIDTH-1:0]   bram_data_out,
  output logic                    init_done
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  bram_init_state_t state_q, state_d;
  logic             init_done_q, init_done_d;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    count;
  logic [CW:0]      occupancy;
  logic             accept;
  logic             pop;
`ifdef BRAM_INIT_CLEAR_EN
  logic [ADDR_WIDTH:0] clr_addr_q, clr_addr_d;
`endif

  // Credits cover both the word in flight from the BRAM and those already buffered.
  assign occupancy  = {1'b0, count} + (CW + 1)'(inflight_q);
  assign req_ready  = init_done_q && (occupancy < (CW + 1)'(RESP_DEPTH));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign init_done  = init_done_q;

  always_comb begin
    state_d       = state_q;
    init_done_d   = init_done_q;
    inflight_d    = accept;
    bram_en       = accept;
    bram_write_en = accept ? req_strobe : '0;
    bram_addr     = req_addr;
    bram_data_in  = req_data;
    if (state_q == RUN) begin
      init_done_d = 1'b1;
    end
`ifdef BRAM_INIT_CLEAR_EN
    clr_addr_d = clr_addr_q;
    // Reset is gated in so the port stays idle while reset is held.
    if (state_q == INIT && !reset) begin
      bram_en       = 1'b1;
      bram_write_en = '1;
      bram_addr     = clr_addr_q[ADDR_WIDTH-1:0];
      bram_data_in  = '0;
      clr_addr_d    = clr_addr_q + (ADDR_WIDTH + 1)'(1);
      if (clr_addr_d[ADDR_WIDTH]) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef BRAM_INIT_CLEAR_EN
      state_q    <= INIT;
      clr_addr_q <= '0;
`else
      state_q    <= RUN;
`endif
      init_done_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
`ifdef BRAM_INIT_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
      state_q     <= state_d;
      init_done_q <= init_done_d;
      inflight_q  <= inflight_d;
    end
  end

  bram_resp_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (inflight_q),
    .push_data(bram_data_out),
    .pop      (pop),
    .head     (resp_data),
    .count    (count)
  );

endmodule
